hex_scan_driver: RTL

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

---
 rtl/hex_scan_driver.sv | 89 ++++++++
 1 files changed

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - time-multiplexed 4-digit hex display scanner
//
// Scans four hex digits out of a 16-bit display register, one digit slot
// every REFRESH_DIV clocks, in order 0,1,2,3. New values are staged in a
// shadow register and copied to the display only at the frame boundary
// (last cycle of slot 3), so a frame never shows a mix of old and new digits.
//
// Optional build macro: HEX_SCAN_BLANK_EN -- blank leading-zero digits 1..3.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   load        in   write strobe, value sampled on the edge where load=1
//   value       in   16 bits, value[3:0] is digit 0, value[15:12] is digit 3
//   digit       out  4 bits, current nibble to the 7-segment decoder {W,X,Y,Z}
//   an          out  4 bits, active-low anode enables, an[i]=0 lights digit i
//   pending     out  a loaded value is waiting for the frame boundary
//   frame_start out  one-cycle pulse in the first cycle of each frame
module hex_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic [15:0]   display;
  logic [15:0]   shadow;
  logic          tick;
  logic          boundary;

  assign tick     = (count == COUNT_MAX);
  assign boundary = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      idx         <= 2'd0;
      display     <= 16'h0000;
      shadow      <= 16'h0000;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      count       <= tick ? '0 : count + CW'(1);
      idx         <= tick ? idx + 2'd1 : idx;
      frame_start <= boundary;
      if (boundary) begin
        // A load landing on the boundary bypasses the shadow entirely.
        if (load) begin
          display <= value;
        end else if (pending) begin
          display <= shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

  // Outputs derive only from registered state, so reset forces them at once
  // and load/value have no combinational path to the pins.
  assign digit = display[{idx, 2'b00} +: 4];

  always_comb begin
    an = ~(4'b0001 << idx);
`ifdef HEX_SCAN_BLANK_EN
    // Digit i>=1 is a leading zero when nibbles i..3 are all zero.
    case (idx)
      2'd1:    if (display[15:4]  == 12'h000) an = 4'b1111;
      2'd2:    if (display[15:8]  == 8'h00)   an = 4'b1111;
      2'd3:    if (display[15:12] == 4'h0)    an = 4'b1111;
      default: ;
    endcase
`endif
  end

endmodule
